// File: rtl/axi4l_csr_pkg.sv
// rtl/axi4l_csr_pkg.sv - response codes, register kinds and kind lookup for the CSR bank
package axi4l_csr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         CSR_MAX_REGS = 64;

  typedef enum logic [1:0] {CSR_RW, CSR_RO, CSR_W1C, CSR_PULSE} csr_kind_e;

  function automatic csr_kind_e csr_kind(input int r,
                                         input logic [CSR_MAX_REGS-1:0] ro_mask,
                                         input logic [CSR_MAX_REGS-1:0] w1c_mask,
                                         input logic [CSR_MAX_REGS-1:0] pulse_mask);
    logic [5:0] i;
    i = r[5:0];
    if (ro_mask[i])    return CSR_RO;
    if (w1c_mask[i])   return CSR_W1C;
    if (pulse_mask[i]) return CSR_PULSE;
    return CSR_RW;
  endfunction

endpackage

// File: rtl/axi4l_csr_cell.sv
// rtl/axi4l_csr_cell.sv - one CSR word whose update rule is fixed by its kind
module axi4l_csr_cell
  import axi4l_csr_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter csr_kind_e             KIND       = CSR_RW,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0]   hw_set,
  output logic [DATA_WIDTH-1:0]   value_o
);

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] bit_en;
  logic [DATA_WIDTH-1:0] wbits;
  logic                  unused_ok;

  for (genvar b = 0; b < DATA_WIDTH/8; b++) begin : g_strb
    assign bit_en[8*b +: 8] = {8{wstrb[b]}};
  end

  assign wbits     = wdata & bit_en;
  assign unused_ok = ^{wr_en, wdata, wstrb, hw_set};

  always_comb begin
    value_d = value_q;
    case (KIND)
      CSR_RW: begin
        if (wr_en) value_d = (value_q & ~bit_en) | wbits;
      end
      // hardware set is applied after the clear so a simultaneous event is never lost
      CSR_W1C: begin
        if (wr_en) value_d = value_q & ~wbits;
        value_d = value_d | hw_set;
      end
      CSR_PULSE: value_d = wr_en ? wbits : '0;
      default:   value_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= (KIND == CSR_RW) ? RESET_VAL : '0;
    else     value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/axi4l_csr_bank.sv
// rtl/axi4l_csr_bank.sv - AXI4-Lite slave register bank with RW/RO/W1C/PULSE words and irq
module axi4l_csr_bank
  import axi4l_csr_pkg::*;
#(
  parameter int                               DATA_WIDTH = 32,
  parameter int                               ADDR_WIDTH = 6,
  parameter int                               NUM_REGS   = 8,
  parameter logic [CSR_MAX_REGS-1:0]          RO_MASK    = '0,
  parameter logic [CSR_MAX_REGS-1:0]          W1C_MASK   = '0,
  parameter logic [CSR_MAX_REGS-1:0]          PULSE_MASK = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                     S_AXI_AWPROT,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                     S_AXI_ARPROT,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status_i,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set_i,
  output logic                           irq_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;

  logic                  aw_held_q, aw_held_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic                  w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  irq_q, irq_d;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]      ar_idx;
  logic [NUM_REGS-1:0]   wr_en;
  logic [DATA_WIDTH-1:0] cell_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_hit, wr_hit, w1c_any;
  logic                  unused_ok;

  assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
  assign S_AXI_ARREADY = !rvalid_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign irq_o         = irq_q;

  assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign commit = aw_held_q && w_held_q;
  assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                       S_AXI_ARADDR[ADDR_LSB-1:0], hw_status_i};

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    axi4l_csr_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .KIND       (csr_kind(g, RO_MASK, W1C_MASK, PULSE_MASK)),
      .RESET_VAL  (RESET_VAL[g*DATA_WIDTH +: DATA_WIDTH])
    ) u_cell (
      .clk     (ACLK),
      .rst     (ARESET),
      .wr_en   (wr_en[g]),
      .wdata   (w_data_q),
      .wstrb   (w_strb_q),
      .hw_set  (hw_set_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .value_o (cell_q[g])
    );
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = cell_q[g];
  end

  // Decode, read mux and irq source; reads see cell contents before any same-edge commit
  always_comb begin
    rd_val  = '0;
    rd_hit  = 1'b0;
    wr_hit  = 1'b0;
    w1c_any = 1'b0;
    wr_en   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (int'(ar_idx) == r) begin
        rd_hit = 1'b1;
        case (csr_kind(r, RO_MASK, W1C_MASK, PULSE_MASK))
          CSR_RO:    rd_val = hw_status_i[r*DATA_WIDTH +: DATA_WIDTH];
          CSR_PULSE: rd_val = '0;
          default:   rd_val = cell_q[r];
        endcase
      end
      if (int'(aw_idx_q) == r) begin
        wr_hit   = 1'b1;
        wr_en[r] = commit;
      end
      if (csr_kind(r, RO_MASK, W1C_MASK, PULSE_MASK) == CSR_W1C)
        w1c_any = w1c_any | (|cell_q[r]);
    end
  end

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    irq_d     = w1c_any;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = S_AXI_WDATA;
      w_strb_d = S_AXI_WSTRB;
    end
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
    end

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      irq_q     <= irq_d;
    end
  end

endmodule

// File: tb/tb_axi4l_csr_bank.sv
// tb/tb_axi4l_csr_bank.sv - randomized self-checking bench for axi4l_csr_bank
module tb_axi4l_csr_bank;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NR = 8;
  localparam int W1C_REG   = 5;
  localparam int PULSE_REG = 6;
  localparam int RO_REG    = 7;
  localparam logic [63:0] RO_M    = 64'(1) << RO_REG;
  localparam logic [63:0] W1C_M   = 64'(1) << W1C_REG;
  localparam logic [63:0] PULSE_M = 64'(1) << PULSE_REG;
  localparam logic [NR*DW-1:0] RV = {32'h0, 32'h0, 32'h0, 32'hC0DE0004,
                                     32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
  localparam logic [NR*DW-1:0] IMG_MASK = {32'h0, {(NR-1)*DW{1'b1}}};

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic [AW-1:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]      S_AXI_AWPROT, S_AXI_ARPROT;
  logic            S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [DW-1:0]   S_AXI_WDATA, S_AXI_RDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic [1:0]      S_AXI_BRESP, S_AXI_RRESP;
  logic            S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic            S_AXI_RVALID, S_AXI_RREADY;
  logic [NR*DW-1:0] regs_o, hw_status_i, hw_set_i;
  logic            irq_o;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model [NR];

  always #5 ACLK = ~ACLK;

  axi4l_csr_bank #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
    .RO_MASK(RO_M), .W1C_MASK(W1C_M), .PULSE_MASK(PULSE_M), .RESET_VAL(RV)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .regs_o(regs_o), .hw_status_i(hw_status_i), .hw_set_i(hw_set_i), .irq_o(irq_o)
  );

  // Reference model: an array of words updated by the per-kind rules
  function automatic void model_reset();
    for (int r = 0; r < NR; r++)
      model[r] = (r == RO_REG || r == W1C_REG || r == PULSE_REG) ? 32'h0 : RV[r*DW +: DW];
  endfunction

  function automatic void model_write(input int idx, input logic [DW-1:0] data, input logic [3:0] strb);
    if (idx >= NR || idx == RO_REG || idx == PULSE_REG) return;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        if (idx == W1C_REG) model[idx][8*b +: 8] = model[idx][8*b +: 8] & ~data[8*b +: 8];
        else                model[idx][8*b +: 8] = data[8*b +: 8];
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_read(input int idx);
    if (idx >= NR || idx == PULSE_REG) return 32'h0;
    if (idx == RO_REG) return hw_status_i[idx*DW +: DW];
    return model[idx];
  endfunction

  function automatic logic [NR*DW-1:0] img_expect();
    logic [NR*DW-1:0] img;
    img = '0;
    for (int r = 0; r < NR; r++)
      if (r != RO_REG && r != PULSE_REG) img[r*DW +: DW] = model[r];
    return img;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int  aw_dly, w_dly, b_dly;
    bit  aw_done, w_done, b_done, aw_hs, w_hs, b_hs;
    aw_dly = $urandom_range(0, 3);
    w_dly  = $urandom_range(0, 3);
    b_dly  = $urandom_range(0, 3);
    aw_done = 0; w_done = 0; b_done = 0;
    resp = 2'bxx;
    S_AXI_AWADDR = addr;
    S_AXI_AWPROT = 3'($urandom);
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    for (int c = 0; c < 60 && !b_done; c++) begin
      S_AXI_AWVALID = !aw_done && aw_dly == 0;
      S_AXI_WVALID  = !w_done && w_dly == 0;
      S_AXI_BREADY  = aw_done && w_done && b_dly == 0;
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      b_hs  = S_AXI_BREADY && S_AXI_BVALID;
      if (b_hs) resp = S_AXI_BRESP;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      if (b_hs) b_done = 1;
      if (aw_dly > 0) aw_dly--;
      if (w_dly > 0) w_dly--;
      if (aw_done && w_done && b_dly > 0) b_dly--;
    end
    S_AXI_AWVALID = 0;
    S_AXI_WVALID  = 0;
    S_AXI_BREADY  = 0;
    if (!b_done) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%h got no B response, required one within 60 cycles", addr);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data, output logic [1:0] resp);
    int ar_dly, r_dly;
    bit ar_done, r_done, ar_hs, r_hs;
    ar_dly = $urandom_range(0, 3);
    r_dly  = $urandom_range(0, 3);
    ar_done = 0; r_done = 0;
    data = 'x; resp = 2'bxx;
    S_AXI_ARADDR = addr;
    S_AXI_ARPROT = 3'($urandom);
    for (int c = 0; c < 60 && !r_done; c++) begin
      S_AXI_ARVALID = !ar_done && ar_dly == 0;
      S_AXI_RREADY  = ar_done && r_dly == 0;
      ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
      r_hs  = S_AXI_RREADY && S_AXI_RVALID;
      if (r_hs) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      tick();
      if (ar_hs) ar_done = 1;
      if (r_hs) r_done = 1;
      if (ar_dly > 0) ar_dly--;
      if (ar_done && r_dly > 0) r_dly--;
    end
    S_AXI_ARVALID = 0;
    S_AXI_RREADY  = 0;
    if (!r_done) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%h got no R response, required one within 60 cycles", addr);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      failures++; $display("FAIL reset_ready got=%b required=111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    checks++;
    if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, irq_o} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b required=0000000",
                           {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, irq_o});
    end
    checks++;
    if (S_AXI_RDATA !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h required=00000000", S_AXI_RDATA);
    end
    checks++;
    if ((regs_o & IMG_MASK) !== img_expect()) begin
      failures++; $display("FAIL reset_image got=%h required=%h", regs_o & IMG_MASK, img_expect());
    end
  endtask

  task automatic test_rw();
    logic [1:0] resp;
    logic [DW-1:0] rd;
    int idx;
    for (int i = 0; i < 4; i++) begin
      axi_write(6'(4*i), 32'(i + 1), 4'hF, resp);
      model_write(i, 32'(i + 1), 4'hF);
      checks++;
      if (resp !== 2'b00) begin failures++; $display("FAIL rw_bresp reg=%0d got=%b required=00", i, resp); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(6'(4*i), rd, resp);
      checks++;
      if (rd !== 32'(i + 1) || resp !== 2'b00) begin
        failures++; $display("FAIL rw_readback reg=%0d got=%h/%b required=%h/00", i, rd, resp, i + 1);
      end
    end
    for (int n = 0; n < 20; n++) begin
      logic [DW-1:0] d;
      logic [3:0] s;
      idx = $urandom_range(0, 4);
      d = $urandom;
      s = 4'($urandom);
      axi_write({idx[3:0], 2'($urandom)}, d, s, resp);
      model_write(idx, d, s);
      idx = $urandom_range(0, 4);
      axi_read({idx[3:0], 2'($urandom)}, rd, resp);
      checks++;
      if (rd !== exp_read(idx) || resp !== 2'b00) begin
        failures++; $display("FAIL rw_random reg=%0d got=%h/%b required=%h/00", idx, rd, resp, exp_read(idx));
      end
    end
    checks++;
    if ((regs_o & IMG_MASK) !== img_expect()) begin
      failures++; $display("FAIL rw_image got=%h required=%h", regs_o & IMG_MASK, img_expect());
    end
  endtask

  task automatic test_strobes();
    logic [1:0] resp;
    logic [DW-1:0] rd;
    axi_write(6'h00, 32'hAABBCCDD, 4'hF, resp);
    axi_write(6'h00, 32'h11223344, 4'b0101, resp);
    model_write(0, 32'hAABBCCDD, 4'hF);
    model_write(0, 32'h11223344, 4'b0101);
    axi_read(6'h00, rd, resp);
    checks++;
    if (rd !== 32'hAA22CC44) begin failures++; $display("FAIL strobe_merge got=%h required=AA22CC44", rd); end
  endtask

  task automatic test_split_handshake();
    logic [1:0] resp;
    logic [DW-1:0] rd;
    S_AXI_WDATA = 32'h5A5A1234; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    checks++;
    if (S_AXI_WREADY !== 1'b1) begin failures++; $display("FAIL split_wready got=%b required=1", S_AXI_WREADY); end
    tick();
    S_AXI_WVALID = 0;
    checks++;
    if ({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID} !== 3'b010) begin
      failures++; $display("FAIL split_w_held got=%b required=010", {S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID});
    end
    tick(); tick();
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    checks++;
    if (S_AXI_BVALID !== 1'b0) begin failures++; $display("FAIL split_early_b got=%b required=0", S_AXI_BVALID); end
    tick();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) begin
        failures++; $display("FAIL split_b_hold cycle=%0d got=%b required=10000", c,
                             {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY});
      end
      tick();
    end
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
    model_write(1, 32'h5A5A1234, 4'hF);
    checks++;
    if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
      failures++; $display("FAIL split_b_done got=%b required=011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
    end
    axi_read(6'h04, rd, resp);
    checks++;
    if (rd !== 32'h5A5A1234) begin failures++; $display("FAIL split_readback got=%h required=5A5A1234", rd); end
  endtask

  task automatic test_w1c_irq();
    logic [1:0] resp;
    logic [DW-1:0] rd;
    hw_set_i[W1C_REG*DW +: DW] = 32'h1;
    tick();
    hw_set_i = '0;
    model[W1C_REG] = model[W1C_REG] | 32'h1;
    checks++;
    if (regs_o[W1C_REG*DW +: DW] !== 32'h1 || irq_o !== 1'b0) begin
      failures++; $display("FAIL w1c_set got=%h irq=%b required=00000001 irq=0", regs_o[W1C_REG*DW +: DW], irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1) begin failures++; $display("FAIL w1c_irq_rise got=%b required=1", irq_o); end
    hw_set_i[W1C_REG*DW +: DW] = 32'h1;
    axi_write(6'h14, 32'h1, 4'hF, resp);
    hw_set_i = '0;
    axi_read(6'h14, rd, resp);
    checks++;
    if (rd !== 32'h1 || irq_o !== 1'b1) begin
      failures++; $display("FAIL w1c_set_wins got=%h irq=%b required=00000001 irq=1", rd, irq_o);
    end
    S_AXI_AWADDR = 6'h14; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    tick();
    model_write(W1C_REG, 32'h1, 4'hF);
    checks++;
    if (regs_o[W1C_REG*DW +: DW] !== 32'h0 || irq_o !== 1'b1 || S_AXI_BVALID !== 1'b1) begin
      failures++; $display("FAIL w1c_clear got=%h irq=%b bvalid=%b required=00000000 irq=1 bvalid=1",
                           regs_o[W1C_REG*DW +: DW], irq_o, S_AXI_BVALID);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0) begin failures++; $display("FAIL w1c_irq_fall got=%b required=0", irq_o); end
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
    for (int n = 0; n < 8; n++) begin
      logic [DW-1:0] s, d;
      logic [3:0] st;
      s = $urandom; d = $urandom; st = 4'($urandom);
      hw_set_i[W1C_REG*DW +: DW] = s;
      tick();
      hw_set_i = '0;
      model[W1C_REG] = model[W1C_REG] | s;
      axi_write(6'h14, d, st, resp);
      model_write(W1C_REG, d, st);
      axi_read(6'h14, rd, resp);
      checks++;
      if (rd !== model[W1C_REG] || irq_o !== (model[W1C_REG] != 0)) begin
        failures++; $display("FAIL w1c_random iter=%0d got=%h irq=%b required=%h irq=%b",
                             n, rd, irq_o, model[W1C_REG], model[W1C_REG] != 0);
      end
    end
    axi_write(6'h14, 32'hFFFFFFFF, 4'hF, resp);
    model_write(W1C_REG, 32'hFFFFFFFF, 4'hF);
  endtask

  task automatic test_pulse_ro();
    logic [1:0] resp;
    logic [DW-1:0] rd;
    S_AXI_AWADDR = 6'h18; S_AXI_WDATA = 32'h3; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    tick();
    checks++;
    if (regs_o[PULSE_REG*DW +: DW] !== 32'h3) begin
      failures++; $display("FAIL pulse_high got=%h required=00000003", regs_o[PULSE_REG*DW +: DW]);
    end
    tick();
    checks++;
    if (regs_o[PULSE_REG*DW +: DW] !== 32'h0) begin
      failures++; $display("FAIL pulse_low got=%h required=00000000", regs_o[PULSE_REG*DW +: DW]);
    end
    S_AXI_BREADY = 1;
    tick();
    S_AXI_BREADY = 0;
    axi_read(6'h18, rd, resp);
    checks++;
    if (rd !== 32'h0 || resp !== 2'b00) begin
      failures++; $display("FAIL pulse_read got=%h/%b required=00000000/00", rd, resp);
    end
    hw_status_i[RO_REG*DW +: DW] = 32'hDEADBEEF;
    axi_read(6'h1C, rd, resp);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ro_read got=%h required=DEADBEEF", rd); end
    axi_write(6'h1C, 32'h12345678, 4'hF, resp);
    checks++;
    if (resp !== 2'b00) begin failures++; $display("FAIL ro_write_resp got=%b required=00", resp); end
    for (int n = 0; n < 4; n++) begin
      hw_status_i[RO_REG*DW +: DW] = $urandom;
      axi_read(6'h1C, rd, resp);
      checks++;
      if (rd !== exp_read(RO_REG)) begin
        failures++; $display("FAIL ro_random got=%h required=%h", rd, exp_read(RO_REG));
      end
    end
    checks++;
    if ((regs_o & IMG_MASK) !== img_expect()) begin
      failures++; $display("FAIL ro_image got=%h required=%h", regs_o & IMG_MASK, img_expect());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] resp;
    logic [DW-1:0] rd, d, old;
    old = model[2];
    d = $urandom;
    S_AXI_AWADDR = 6'h08; S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    tick();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    S_AXI_ARADDR = 6'h08; S_AXI_ARVALID = 1;
    tick();
    S_AXI_ARVALID = 0;
    model_write(2, d, 4'hF);
    checks++;
    if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b11 || S_AXI_RDATA !== old) begin
      failures++; $display("FAIL same_cycle_rw got=%h valid=%b required=%h valid=11",
                           S_AXI_RDATA, {S_AXI_RVALID, S_AXI_BVALID}, old);
    end
    S_AXI_RREADY = 1; S_AXI_BREADY = 1;
    tick();
    S_AXI_RREADY = 0; S_AXI_BREADY = 0;
    for (int n = 0; n < 30; n++) begin
      int idx;
      logic [3:0] st;
      idx = $urandom_range(0, 15);
      d = $urandom;
      st = 4'($urandom);
      hw_status_i[RO_REG*DW +: DW] = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        axi_write({idx[3:0], 2'($urandom)}, d, st, resp);
        model_write(idx, d, st);
        checks++;
        if (resp !== ((idx < NR) ? 2'b00 : 2'b10)) begin
          failures++; $display("FAIL mix_bresp reg=%0d got=%b required=%b", idx, resp, (idx < NR) ? 2'b00 : 2'b10);
        end
      end else begin
        axi_read({idx[3:0], 2'($urandom)}, rd, resp);
        checks++;
        if (rd !== exp_read(idx) || resp !== ((idx < NR) ? 2'b00 : 2'b10)) begin
          failures++; $display("FAIL mix_read reg=%0d got=%h/%b required=%h/%b", idx, rd, resp,
                               exp_read(idx), (idx < NR) ? 2'b00 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_errors_reset();
    logic [1:0] resp;
    logic [DW-1:0] rd;
    bit b_seen;
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, resp);
    checks++;
    if (resp !== 2'b10) begin failures++; $display("FAIL err_bresp got=%b required=10", resp); end
    axi_read(6'h20, rd, resp);
    checks++;
    if (rd !== 32'h0 || resp !== 2'b10) begin
      failures++; $display("FAIL err_read got=%h/%b required=00000000/10", rd, resp);
    end
    checks++;
    if ((regs_o & IMG_MASK) !== img_expect()) begin
      failures++; $display("FAIL err_image got=%h required=%h", regs_o & IMG_MASK, img_expect());
    end
    S_AXI_AWADDR = 6'h00; S_AXI_AWVALID = 1;
    tick();
    S_AXI_AWVALID = 0;
    ARESET = 1;
    tick();
    ARESET = 0;
    model_reset();
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq_o} !== 6'b111000
        || S_AXI_RDATA !== 32'h0 || {S_AXI_BRESP, S_AXI_RRESP} !== 4'b0) begin
      failures++; $display("FAIL midreset_outputs got=%b rdata=%h resp=%b required=111000 rdata=0 resp=0000",
                           {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, irq_o},
                           S_AXI_RDATA, {S_AXI_BRESP, S_AXI_RRESP});
    end
    S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
    tick();
    S_AXI_WVALID = 0;
    b_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (S_AXI_BVALID) b_seen = 1;
      tick();
    end
    checks++;
    if (b_seen) begin failures++; $display("FAIL midreset_no_b got=bvalid required=no bvalid"); end
    checks++;
    if ((regs_o & IMG_MASK) !== img_expect()) begin
      failures++; $display("FAIL midreset_image got=%h required=%h", regs_o & IMG_MASK, img_expect());
    end
    ARESET = 1;
    tick();
    ARESET = 0;
  endtask

  initial begin
    ARESET = 1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    hw_status_i = '0; hw_set_i = '0;
    for (int r = 0; r < NR; r++) hw_status_i[r*DW +: DW] = $urandom;
    model_reset();
    tick(); tick(); tick();
    ARESET = 0;
    test_reset();
    test_rw();
    test_strobes();
    test_split_handshake();
    test_w1c_irq();
    test_pulse_ro();
    test_back_to_back();
    test_errors_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
